// File: rtl/aud_dsp_pkg.sv
// Shared types and helpers for the multichannel audio playback engine.
package aud_dsp_pkg;

    typedef enum logic [1:0] {
        NORM        = 2'd0,
        SLOW_HOLD   = 2'd1,
        FAST        = 2'd2,
        SLOW_INTERP = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CALC  = 3'd2,
        WAIT  = 3'd3,
        PAUSE = 3'd4
    } state_e;

    // Bit offset of channel c inside a packed frame.
    function automatic int ch_lsb(input int c, input int data_w);
        return c * data_w;
    endfunction

endpackage

// File: rtl/aud_lerp.sv
// One channel of signed linear interpolation: (cur*(k-phase) + nxt*phase) / k.
module aud_lerp #(
    parameter int DATA_W  = 16,
    parameter int SPEED_W = 3
) (
    input  logic [DATA_W-1:0]  i_cur,
    input  logic [DATA_W-1:0]  i_nxt,
    input  logic [SPEED_W-1:0] i_phase,
    input  logic [SPEED_W:0]   i_k,
    output logic [DATA_W-1:0]  o_out
);
    localparam int W = DATA_W + SPEED_W + 2;

    logic signed [W-1:0] cur_x, nxt_x, k_x, ph_x, sum_x, quo_x;

    always_comb begin
        cur_x = {{(W-DATA_W){i_cur[DATA_W-1]}}, i_cur};
        nxt_x = {{(W-DATA_W){i_nxt[DATA_W-1]}}, i_nxt};
        k_x   = {{(W-SPEED_W-1){1'b0}}, i_k};
        ph_x  = {{(W-SPEED_W){1'b0}}, i_phase};
        sum_x = cur_x * (k_x - ph_x) + nxt_x * ph_x;
        // Signed division truncates toward zero; result stays between cur and nxt.
        quo_x = sum_x / k_x;
        o_out = quo_x[DATA_W-1:0];
    end

endmodule

// File: rtl/aud_dsp_mc.sv
// Multichannel playback engine: fetches interleaved PCM frames from SRAM and
// emits one prepared frame per falling edge of the DAC LR clock.
module aud_dsp_mc
    import aud_dsp_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CH      = 2,
    parameter int ADDR_W  = 20,
    parameter int SPEED_W = 3,
    parameter int RD_LAT  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_pause,
    input  logic                 i_stop,
    input  logic [SPEED_W-1:0]   i_speed,
    input  logic [1:0]           i_mode,
    input  logic                 i_reverse,
    input  logic                 i_daclrck,
    input  logic [ADDR_W-1:0]    i_last_frame,
    input  logic [DATA_W-1:0]    i_sram_data,
    output logic [ADDR_W-1:0]    o_sram_addr,
    output logic                 o_sram_rd,
    output logic [CH*DATA_W-1:0] o_dac_data,
    output logic                 o_dac_valid,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int PW  = CH * DATA_W;
    localparam int KW  = SPEED_W + 1;
    localparam int AW1 = ADDR_W + 1;
    localparam int CW  = $clog2(2 * CH + RD_LAT + 1) + 1;

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [KW-1:0]       k_q, k_d;
    logic                rev_q, rev_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [SPEED_W-1:0]  phase_q, phase_d;
    logic                pause_pending_q, pause_pending_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [PW-1:0]       cur_q, cur_d, nxt_q, nxt_d, prep_q, prep_d;
    logic [PW-1:0]       dac_data_q, dac_data_d;
    logic                dac_valid_q, dac_valid_d, done_q, done_d;
    logic [2:0]          lr_sync_q, lr_sync_d;

    logic                tick;
    logic [PW-1:0]       lerp_out;
    logic [CW-1:0]       n_rd, cap_idx, chan;
    logic                rd_active, capture, last_cap;
    logic [ADDR_W-1:0]   nbr, frame, ptr_adv;
    logic                slow, move, end_play;
    logic [AW1-1:0]      step_eff, fwd;
    logic [SPEED_W-1:0]  phase_adv, phase_clamped;
    logic [KW-1:0]       k_new;

    // Index 1 is the synchronised LR clock, index 2 its previous value.
    assign lr_sync_d = {lr_sync_q[1:0], i_daclrck};
    assign tick      = lr_sync_q[2] & ~lr_sync_q[1];

    always_comb begin
        n_rd      = (mode_q == SLOW_INTERP) ? CW'(2 * CH) : CW'(CH);
        rd_active = (state_q == FETCH) && (cyc_q < n_rd);
        cap_idx   = cyc_q - CW'(RD_LAT);
        capture   = (state_q == FETCH) && (cyc_q >= CW'(RD_LAT)) && (cap_idx < n_rd);
        last_cap  = (state_q == FETCH) && (cyc_q == n_rd + CW'(RD_LAT) - CW'(1));

        if (rev_q) begin
            nbr = (ptr_q == '0) ? ptr_q : ptr_q - ADDR_W'(1);
        end else begin
            nbr = (ptr_q >= i_last_frame) ? ptr_q : ptr_q + ADDR_W'(1);
        end
        frame = (cyc_q < CW'(CH)) ? ptr_q : nbr;
        chan  = (cyc_q < CW'(CH)) ? cyc_q : cyc_q - CW'(CH);
    end

    assign o_sram_rd   = rd_active;
    assign o_sram_addr = rd_active ? (frame * ADDR_W'(CH) + ADDR_W'(chan)) : '0;

    // Frame advance; slow modes only move the pointer when the phase wraps.
    always_comb begin
        slow = (mode_q == SLOW_HOLD) || (mode_q == SLOW_INTERP);
        move = 1'b1;
        phase_adv = phase_q;
        if (slow) begin
            if ({1'b0, phase_q} != k_q - KW'(1)) begin
                move      = 1'b0;
                phase_adv = phase_q + SPEED_W'(1);
            end else begin
                phase_adv = '0;
            end
        end
        if (!move) begin
            step_eff = '0;
        end else if (mode_q == FAST) begin
            step_eff = AW1'(k_q);
        end else begin
            step_eff = AW1'(1);
        end
        fwd      = {1'b0, ptr_q} + step_eff;
        end_play = rev_q ? ({1'b0, ptr_q} < step_eff) : (fwd > {1'b0, i_last_frame});
        ptr_adv  = rev_q ? (ptr_q - step_eff[ADDR_W-1:0]) : fwd[ADDR_W-1:0];
        k_new    = {1'b0, i_speed} + KW'(1);
        phase_clamped = ({1'b0, phase_adv} >= k_new) ? '0 : phase_adv;
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_lerp
        aud_lerp #(
            .DATA_W (DATA_W),
            .SPEED_W(SPEED_W)
        ) u_lerp (
            .i_cur  (cur_q[ch_lsb(gi, DATA_W) +: DATA_W]),
            .i_nxt  (nxt_q[ch_lsb(gi, DATA_W) +: DATA_W]),
            .i_phase(phase_q),
            .i_k    (k_q),
            .o_out  (lerp_out[ch_lsb(gi, DATA_W) +: DATA_W])
        );
    end

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        k_d             = k_q;
        rev_d           = rev_q;
        ptr_d           = ptr_q;
        phase_d         = phase_q;
        pause_pending_d = pause_pending_q;
        cyc_d           = cyc_q;
        cur_d           = cur_q;
        nxt_d           = nxt_q;
        prep_d          = prep_q;
        dac_data_d      = dac_data_q;
        dac_valid_d     = 1'b0;
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                dac_data_d      = '0;
                pause_pending_d = 1'b0;
                if (i_start) begin
                    state_d = FETCH;
                    ptr_d   = i_reverse ? i_last_frame : '0;
                    phase_d = '0;
                    mode_d  = mode_e'(i_mode);
                    k_d     = k_new;
                    rev_d   = i_reverse;
                    cyc_d   = '0;
                end
            end
            FETCH: begin
                cyc_d = cyc_q + CW'(1);
                if (i_pause) pause_pending_d = 1'b1;
                for (int c = 0; c < CH; c++) begin
                    if (capture && cap_idx == CW'(c))
                        cur_d[ch_lsb(c, DATA_W) +: DATA_W] = i_sram_data;
                    if (capture && cap_idx == CW'(CH + c))
                        nxt_d[ch_lsb(c, DATA_W) +: DATA_W] = i_sram_data;
                end
                if (last_cap) state_d = CALC;
            end
            CALC: begin
                if (i_pause) pause_pending_d = 1'b1;
                prep_d  = (mode_q == SLOW_INTERP) ? lerp_out : cur_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (tick) begin
                    dac_data_d  = prep_q;
                    dac_valid_d = 1'b1;
                    if (end_play) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // New mode/speed/direction are picked up for the next frame.
                        ptr_d   = ptr_adv;
                        phase_d = phase_clamped;
                        mode_d  = mode_e'(i_mode);
                        k_d     = k_new;
                        rev_d   = i_reverse;
                        cyc_d   = '0;
                        state_d = FETCH;
                    end
                end else if (pause_pending_q || i_pause) begin
                    pause_pending_d = 1'b0;
                    state_d         = PAUSE;
                end
            end
            PAUSE: begin
                dac_data_d = '0;
                if (i_start) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase

        if (i_stop && state_q != IDLE) begin
            state_d         = IDLE;
            dac_data_d      = '0;
            dac_valid_d     = 1'b0;
            done_d          = 1'b0;
            pause_pending_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            mode_q          <= NORM;
            k_q             <= KW'(1);
            rev_q           <= 1'b0;
            ptr_q           <= '0;
            phase_q         <= '0;
            pause_pending_q <= 1'b0;
            cyc_q           <= '0;
            cur_q           <= '0;
            nxt_q           <= '0;
            prep_q          <= '0;
            dac_data_q      <= '0;
            dac_valid_q     <= 1'b0;
            done_q          <= 1'b0;
            lr_sync_q       <= '0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            k_q             <= k_d;
            rev_q           <= rev_d;
            ptr_q           <= ptr_d;
            phase_q         <= phase_d;
            pause_pending_q <= pause_pending_d;
            cyc_q           <= cyc_d;
            cur_q           <= cur_d;
            nxt_q           <= nxt_d;
            prep_q          <= prep_d;
            dac_data_q      <= dac_data_d;
            dac_valid_q     <= dac_valid_d;
            done_q          <= done_d;
            lr_sync_q       <= lr_sync_d;
        end
    end

    assign o_dac_data  = dac_data_q;
    assign o_dac_valid = dac_valid_q;
    assign o_done      = done_q;
    assign o_busy      = (state_q != IDLE);

    // The fetch pipeline must finish well inside one LR period.
    tick_outside_pipeline_a: assert property (@(posedge i_clk) disable iff (i_rst)
        !(tick && (state_q == FETCH || state_q == CALC)));

endmodule
